// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential word fetches over req/gnt/rvalid, buffered {inst, pc} with redirect flush.
// Optional IFQ_BYPASS_EN: a live response reaching an empty queue is presented to the core in the same cycle.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    cnt_t        head_q, head_d, tail_q, tail_d, count_q, count_d;
    cnt_t        out_q, out_d, drop_q, drop_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;

    logic [CW:0] used;
    logic        credit_ok, issue, rsp_drop, rsp_live, buf_valid;
    logic        push, pop, byp_consume;
    logic [AW-1:0] head_idx, tail_idx;

    assign head_idx  = head_q[AW-1:0];
    assign tail_idx  = tail_q[AW-1:0];
    assign buf_valid = (count_q != '0);

    assign used      = {1'b0, count_q} + {1'b0, out_q} + {1'b0, drop_q};
    assign credit_ok = (used < DEPTH_W);
    assign mem_req   = !rst && !redirect && credit_ok;
    assign mem_addr  = fetch_pc_q;
    assign issue     = mem_req && mem_gnt;

    // A response with nothing outstanding and nothing to drop is a protocol error and is ignored.
    assign rsp_drop  = mem_rvalid && (drop_q != '0);
    assign rsp_live  = mem_rvalid && (drop_q == '0) && (out_q != '0);

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass      = rsp_live && !buf_valid && !redirect;
    assign byp_consume = bypass && inst_ready;
    assign inst_valid  = buf_valid || bypass;
    assign inst        = buf_valid ? inst_mem_q[head_idx] : (bypass ? mem_rdata : '0);
    assign inst_pc     = buf_valid ? pc_mem_q[head_idx]   : (bypass ? rsp_pc_q  : '0);
`else
    assign byp_consume = 1'b0;
    assign inst_valid  = buf_valid;
    // NOTE: the buffer is not reset; gating with buf_valid gives zero outputs after reset instead.
    assign inst        = buf_valid ? inst_mem_q[head_idx] : '0;
    assign inst_pc     = buf_valid ? pc_mem_q[head_idx]   : '0;
`endif

    assign push = rsp_live && !byp_consume;
    assign pop  = buf_valid && inst_ready;

    // NOTE: every next-state signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;

        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            out_d      = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            // Everything still in flight becomes stale, less the response landing this cycle.
            drop_d     = drop_q + out_q - cnt_t'(rsp_drop || rsp_live);
        end else begin
            if (issue)    fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_live) rsp_pc_d   = rsp_pc_q + 32'd4;
            if (rsp_drop) drop_d     = drop_q - cnt_t'(1);
            out_d = out_q + cnt_t'(issue) - cnt_t'(rsp_live);
            if (push) tail_d = tail_q + cnt_t'(1);
            if (pop)  head_d = head_q + cnt_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            inst_mem_q[tail_idx] <= mem_rdata;
            pc_mem_q[tail_idx]   <= rsp_pc_q;
        end
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue sitting directly upstream of the pipeline's IF stage. It issues sequential word fetches to an instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs. It presents instructions to the core through a valid/ready interface. A core redirect (branch mispredict, JAL/JALR) flushes all buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- DEPTH, 4, queue entries and the maximum number of in-flight requests; a power of two, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch byte address, word aligned
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid; responses return in request order
- mem_rdata  in  32  returned instruction word
- redirect  in  1  flush the queue and refetch from redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction
- inst_pc  out  32  PC of the head instruction
- inst_ready  in  1  core consumes the head this cycle

## Operation
- State:
  - fetch_pc: next address to request
  - rsp_pc: PC of the oldest live outstanding request
  - circular buffer of DEPTH {inst, pc} entries with head/tail pointers and count
  - outstanding: live in-flight request count
  - drop_cnt: stale in-flight responses still to be discarded
- Credit rule: count + outstanding + drop_cnt < DEPTH.
- mem_req is high when the credit rule holds, redirect is low and rst is low. mem_addr = fetch_pc.
- Issue (mem_req && mem_gnt): fetch_pc += 4 (mod 2^32); outstanding++.
- Response (mem_rvalid):
  - drop_cnt > 0: discard the word; drop_cnt--.
  - Otherwise: push {mem_rdata, rsp_pc}; rsp_pc += 4; outstanding--.
- Pop (inst_valid && inst_ready): head advances; count--.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Overflow is impossible by construction of the credit rule. A response arriving while outstanding == 0 and drop_cnt == 0 is a protocol error; ignore it.
- inst_valid = (count != 0). inst and inst_pc come from the head entry. Head data is held stable while inst_ready is low.
- Redirect (highest priority):
  - count <= 0; fetch_pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}
  - drop_cnt <= drop_cnt + outstanding − (1 if a response arrives this cycle)
  - outstanding <= 0
  - Any pop that cycle is ignored.
- Pointer/count arithmetic is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset, applied asynchronously:
  - mem_req=0, inst_valid=0, inst=0, inst_pc=0
  - fetch_pc=rsp_pc=RESET_PC
  - count=outstanding=drop_cnt=0
- First mem_req is high in the first clock cycle after rst deasserts.
- Issue throughput: one request per cycle while credits allow.
- Response-to-inst_valid latency: 1 cycle (data registered into the buffer). The bypass option reduces this to 0; see Configuration.
- Redirect in cycle N:
  - mem_req is low in cycle N.
  - inst_valid is low in cycle N+1.
  - The first request to the new PC issues in cycle N+1 if credits allow.
  - The first new instruction appears no earlier than 1 cycle after its response.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests must not arrive after reset; this is the memory's obligation.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count == 0 and a live (non-dropped) response arrives, inst_valid, inst and inst_pc are driven combinationally from mem_rvalid, mem_rdata and rsp_pc in the same cycle.
  - If inst_ready is also high, the word is consumed and not written to the buffer.
  - redirect suppresses the bypass.
- IFQ_BYPASS_EN undefined:
  - All outputs come from the buffer registers only; no combinational path exists from mem_* to inst_*.

## Test plan
- Reset, mem_gnt=1, single-cycle memory returning addr as data, inst_ready=1:
  - mem_addr is 0,4,8,… on consecutive cycles.
  - inst/inst_pc pairs are 0/0, 4/4, 8/8 in order, with no gaps after fill.
- inst_ready=0 for 10 cycles, DEPTH=4:
  - Exactly 4 grants are issued, then mem_req stays low.
  - Head is held at PC 0.
  - Releasing ready drains PCs 0,4,8,12 followed by 16.
- Memory with 3-cycle response latency, then redirect to 0x100 with 2 requests in flight:
  - Both stale responses are dropped.
  - The next delivered instruction has inst_pc=0x100.
- redirect_pc=0x203:
  - mem_addr=0x200, inst_pc=0x200.
- Redirect in the same cycle as an arriving response and an inst_ready pop:
  - Queue empty next cycle; drop_cnt equals outstanding−1.
  - No stale PC is ever presented.
- Response arriving with count=0:
  - With IFQ_BYPASS_EN: inst_valid high the same cycle.
  - Without IFQ_BYPASS_EN: inst_valid high exactly one cycle later.
